// File: rtl/debug_hw_pkg.sv
// debug_hw_pkg: shared channel index type and default timing constants for the
// debug LED / button front end.
package debug_hw_pkg;
    localparam int MAX_CH = 8;
    typedef logic [$clog2(MAX_CH)-1:0] ch_idx_t;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 240_000;
    localparam int DEFAULT_BLINK_CYCLES    = 12_000_000;
    localparam int DEFAULT_SCAN_CYCLES     = 48_000_000;
endpackage

// File: rtl/debug_btn_debounce.sv
// debug_btn_debounce: synchronizes an active-low pad, filters it for DEBOUNCE_CYCLES
// stable cycles and emits a one-cycle pulse on each accepted press.
module debug_btn_debounce
    import debug_hw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q + CW'(1);
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end
        press_d = stable_d & ~stable_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= ~btn_n;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press = press_q;
endmodule

// File: rtl/debug_hw_ctrl.sv
// debug_hw_ctrl: arbitrates the 8-bit debug LED bank between NUM_CH channels with
// button A stepping and button B freezing. DEBUG_HW_AUTOSCAN_EN adds an auto-step timer.
module debug_hw_ctrl
    import debug_hw_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int BLINK_CYCLES    = DEFAULT_BLINK_CYCLES
`ifdef DEBUG_HW_AUTOSCAN_EN
    ,
    parameter int SCAN_CYCLES     = DEFAULT_SCAN_CYCLES
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      btnA,
    input  logic                      btnB,
    input  logic [NUM_CH*8-1:0]       ch_bits,
    input  logic [NUM_CH-1:0]         ch_valid,
    output logic [7:0]                bits,
    output logic                      red,
    output logic                      green,
    output logic                      blue,
    output logic [$clog2(NUM_CH)-1:0] sel
);
    localparam int SW = $clog2(NUM_CH);
    localparam int HW = $clog2(BLINK_CYCLES + 1);

    logic          press_a, press_b, adv, hb_wrap;
    logic [SW-1:0] sel_q, sel_d, nxt;
    logic          frozen_q, frozen_d, red_q, blue_q, blue_d, green_q, green_d;
    logic [7:0]    bits_q, bits_d, snap_q, snap_d;
    logic [HW-1:0] hb_q, hb_d;
`ifdef DEBUG_HW_AUTOSCAN_EN
    localparam int SCW = $clog2(SCAN_CYCLES + 1);
    logic [SCW-1:0] scan_q, scan_d;
`endif

    debug_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_a (
        .clk(clk), .rst(rst), .btn_n(btnA), .press(press_a)
    );
    debug_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_b (
        .clk(clk), .rst(rst), .btn_n(btnB), .press(press_b)
    );

    // Descending scan so the nearest valid index above sel wins.
    always_comb begin
        nxt = sel_q;
        for (int k = NUM_CH - 1; k >= 1; k--) begin
            if (ch_valid[SW'((int'(sel_q) + k) % NUM_CH)]) nxt = SW'((int'(sel_q) + k) % NUM_CH);
        end
    end

    always_comb begin
        adv = press_a & ~frozen_q;
`ifdef DEBUG_HW_AUTOSCAN_EN
        adv    = adv | (~frozen_q & (scan_q == SCW'(SCAN_CYCLES - 1)));
        scan_d = frozen_q ? scan_q : (adv ? '0 : scan_q + SCW'(1));
`endif
        sel_d    = adv ? nxt : sel_q;
        frozen_d = frozen_q ^ press_b;
        snap_d   = (press_b & ~frozen_q) ? bits_q : snap_q;
        bits_d   = frozen_q ? snap_q : (ch_valid[sel_q] ? ch_bits[{sel_q, 3'b000} +: 8] : 8'h00);
        blue_d   = ~ch_valid[sel_q];
        hb_wrap  = hb_q == HW'(BLINK_CYCLES - 1);
        hb_d     = hb_wrap ? '0 : hb_q + HW'(1);
        green_d  = green_q ^ hb_wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q    <= '0;
            frozen_q <= 1'b0;
            red_q    <= 1'b0;
            blue_q   <= 1'b0;
            green_q  <= 1'b0;
            bits_q   <= '0;
            snap_q   <= '0;
            hb_q     <= '0;
`ifdef DEBUG_HW_AUTOSCAN_EN
            scan_q   <= '0;
`endif
        end else begin
            sel_q    <= sel_d;
            frozen_q <= frozen_d;
            red_q    <= frozen_q;
            blue_q   <= blue_d;
            green_q  <= green_d;
            bits_q   <= bits_d;
            snap_q   <= snap_d;
            hb_q     <= hb_d;
`ifdef DEBUG_HW_AUTOSCAN_EN
            scan_q   <= scan_d;
`endif
        end
    end

    assign bits  = bits_q;
    assign red   = red_q;
    assign green = green_q;
    assign blue  = blue_q;
    assign sel   = sel_q;
endmodule

// File: tb/tb_debug_hw_ctrl.sv
// tb_debug_hw_ctrl: directed and randomized stimulus; a behavioural model queues the
// expected outputs each cycle and a separate monitor compares them with the DUT.
`timescale 1ns/1ps
module tb_debug_hw_ctrl;
    localparam int NUM_CH = 4;
    localparam int DEB    = 4;
    localparam int BLINK  = 8;
`ifdef DEBUG_HW_AUTOSCAN_EN
    localparam int SCAN   = 20;
`endif
    localparam int SW     = $clog2(NUM_CH);

    logic                 clk = 1'b0;
    logic                 rst, btnA, btnB;
    logic [NUM_CH*8-1:0]  ch_bits;
    logic [NUM_CH-1:0]    ch_valid;
    logic [7:0]           bits;
    logic                 red, green, blue;
    logic [SW-1:0]        sel;

    typedef struct {
        logic [SW-1:0] sel;
        logic [7:0]    bits;
        logic          red;
        logic          blue;
        logic          green;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;

    debug_hw_ctrl #(
        .NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(DEB), .BLINK_CYCLES(BLINK)
`ifdef DEBUG_HW_AUTOSCAN_EN
        , .SCAN_CYCLES(SCAN)
`endif
    ) dut (
        .clk(clk), .rst(rst), .btnA(btnA), .btnB(btnB), .ch_bits(ch_bits),
        .ch_valid(ch_valid), .bits(bits), .red(red), .green(green), .blue(blue), .sel(sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s t=%0t actual=0x%0h expected=0x%0h", name, $time, act, want);
        end
    endtask

    // Reference model state
    logic [SW-1:0] m_sel, osel;
    logic [7:0]    m_bits, m_snap, obits;
    logic          m_frz, m_red, m_blue, ofrz, pa, pb, adv, lvl;
    int            m_n, m_ticks;
    logic          s1[2], s2[2], st[2], pul[2];
    int            run[2];

    function automatic logic [SW-1:0] next_valid(input logic [SW-1:0] cur, input logic [NUM_CH-1:0] v);
        for (int k = 1; k < NUM_CH; k++)
            if (v[SW'((int'(cur) + k) % NUM_CH)]) return SW'((int'(cur) + k) % NUM_CH);
        return cur;
    endfunction

    task automatic model_reset();
        m_sel = '0; m_bits = '0; m_snap = '0; m_frz = 0; m_red = 0; m_blue = 0;
        m_n = 0; m_ticks = 0;
        for (int b = 0; b < 2; b++) begin
            s1[b] = 0; s2[b] = 0; st[b] = 0; pul[b] = 0; run[b] = 0;
        end
    endtask

    task automatic model_step();
        pa = pul[0]; pb = pul[1];
        osel = m_sel; ofrz = m_frz; obits = m_bits;
        m_bits = ofrz ? m_snap : (ch_valid[osel] ? ch_bits[8*osel +: 8] : 8'h00);
        m_red  = ofrz;
        m_blue = !ch_valid[osel];
        adv = pa && !ofrz;
`ifdef DEBUG_HW_AUTOSCAN_EN
        if (!ofrz) begin
            m_ticks++;
            if (adv || m_ticks == SCAN) begin
                adv = 1;
                m_ticks = 0;
            end
        end
`endif
        if (adv) m_sel = next_valid(osel, ch_valid);
        if (pb) begin
            if (!ofrz) m_snap = obits;
            m_frz = !ofrz;
        end
        m_n++;
        // A button is accepted once its synchronized level has differed from the accepted level for DEB cycles
        for (int b = 0; b < 2; b++) begin
            lvl = (b == 0) ? !btnA : !btnB;
            pul[b] = 0;
            if (s2[b] != st[b]) begin
                run[b]++;
                if (run[b] == DEB) begin
                    st[b] = s2[b];
                    run[b] = 0;
                    pul[b] = st[b];
                end
            end else begin
                run[b] = 0;
            end
            s2[b] = s1[b];
            s1[b] = lvl;
        end
        exp_q.push_back('{sel: m_sel, bits: m_bits, red: m_red, blue: m_blue,
                          green: ((m_n / BLINK) % 2) == 1});
    endtask

    initial forever begin
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
    end

    initial forever begin
        @(negedge clk);
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_sel", int'(sel), int'(e.sel));
            chk("sb_bits", int'(bits), int'(e.bits));
            chk("sb_red", int'(red), int'(e.red));
            chk("sb_blue", int'(blue), int'(e.blue));
            chk("sb_green", int'(green), int'(e.green));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input bit b, input int hold);
        if (b) btnB = 0;
        else btnA = 0;
        cyc(hold);
        btnA = 1;
        btnB = 1;
        cyc(DEB + 6);
    endtask

    task automatic do_reset(input int n);
        rst = 1;
        exp_q.delete();
        cyc(n);
        rst = 0;
    endtask

    initial begin
        rst = 1; btnA = 1; btnB = 1;
        ch_bits = 32'h4433_2211; ch_valid = 4'b1111;
        cyc(3);
        chk("rst_sel", int'(sel), 0);
        chk("rst_bits", int'(bits), 0);
        rst = 0;
        cyc(1);
        chk("post_rst_bits", int'(bits), 'h11);
        chk("post_rst_red", int'(red), 0);
        chk("post_rst_green", int'(green), 0);
`ifndef DEBUG_HW_AUTOSCAN_EN
        btnA = 0; cyc(3); btnA = 1; cyc(10);
        chk("glitch_sel", int'(sel), 0);
        btnA = 0; cyc(6);
        chk("a_sel_early", int'(sel), 0);
        cyc(1);
        chk("a_sel", int'(sel), 1);
        cyc(1);
        chk("a_bits", int'(bits), 'h22);
        cyc(2); btnA = 1; cyc(10);
        repeat (3) press(0, 8);
        chk("wrap_all_sel", int'(sel), 0);
        ch_valid = 4'b1001;
        press(0, 8);
        chk("skip_sel", int'(sel), 3);
        chk("skip_bits", int'(bits), 'h44);
        press(0, 8);
        chk("skip_wrap_sel", int'(sel), 0);
        ch_valid = 4'b1111;
        press(0, 8);
        press(1, 8);
        ch_bits[15:8] = 8'hAA;
        cyc(3);
        chk("frz_bits", int'(bits), 'h22);
        chk("frz_red", int'(red), 1);
        press(0, 8);
        chk("frz_a_ignored", int'(sel), 1);
        press(1, 8);
        chk("unfrz_red", int'(red), 0);
        chk("unfrz_bits", int'(bits), 'hAA);
        ch_valid = 4'b0001;
        press(0, 8);
        chk("single_sel", int'(sel), 0);
        ch_valid = 4'b0000;
        cyc(2);
        chk("novalid_bits", int'(bits), 0);
        chk("novalid_blue", int'(blue), 1);
        ch_valid = 4'b1111; ch_bits = 32'h4433_2211;
        cyc(2);
        btnA = 0; btnB = 0; cyc(8); btnA = 1; btnB = 1; cyc(10);
        chk("ab_sel", int'(sel), 1);
        chk("ab_red", int'(red), 1);
        chk("ab_bits", int'(bits), 'h11);
        press(1, 8);
        chk("ab_unfrz_bits", int'(bits), 'h22);
`else
        do_reset(2);
        cyc(19);
        chk("scan_early", int'(sel), 0);
        cyc(1);
        chk("scan_first", int'(sel), 1);
        press(1, 8);
        cyc(45);
        chk("scan_frozen", int'(sel), 1);
        press(1, 8);
        cyc(1);
        chk("scan_resume_early", int'(sel), 1);
        cyc(1);
        chk("scan_resume", int'(sel), 2);
`endif
        for (int seg = 0; seg < 400; seg++) begin
            btnA = ($urandom_range(0, 1) == 0);
            btnB = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 10)) begin
                if ($urandom_range(0, 3) == 0) ch_bits = $urandom;
                if ($urandom_range(0, 15) == 0) ch_valid = NUM_CH'($urandom_range(0, 15));
                cyc(1);
            end
            if ($urandom_range(0, 49) == 0) do_reset($urandom_range(1, 3));
        end
        btnA = 1; btnB = 1;
        cyc(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
